// File: rtl/vidc_clk_meter.sv
// Pixel-clock frequency meter: counts synchronised toggle edges over a fixed
// sys_clk gate window and tracks whether successive counts agree.
module vidc_clk_meter #(
    parameter int GATE_CYCLES = 62500,
    parameter int CW          = 16,
    parameter int TOL         = 4,
    parameter int STABLE_N    = 3,
    parameter int MIN_EDGES   = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_tgl_in,
    output logic [CW-1:0] meas_count,
    output logic          meas_valid,
    output logic          clk_stable,
    output logic          clk_changed,
    output logic          clk_absent
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int MW = $clog2(STABLE_N + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] MIN_E     = CW'(MIN_EDGES);
    localparam logic [CW:0]   TOL_X     = (CW+1)'(TOL);
    localparam logic [MW-1:0] MC_DONE   = MW'(STABLE_N);

    typedef enum logic {ACQUIRE, STABLE} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_s1, r_s2, r_s3;
    logic [GW-1:0]  r_gate;
    logic [CW-1:0]  r_edge_cnt;
    logic           r_first;
    logic [CW-1:0]  r_ref, w_ref_nxt;
    logic [MW-1:0]  r_match_cnt, w_mc_nxt;
    logic [CW-1:0]  r_meas_count;
    logic           r_meas_valid;
    logic           r_changed, w_changed_nxt;
    logic           r_absent;

    logic           w_edge, w_term, w_accept, w_absent, w_in_tol;
    logic [CW-1:0]  w_result;
    logic [CW:0]    w_m_x, w_ref_x, w_diff;

    assign w_edge   = r_s2 ^ r_s3;
    assign w_term   = (r_gate == GATE_LAST);
    // An edge landing on the terminal cycle still belongs to the closing window.
    assign w_result = (r_edge_cnt == CNT_MAX) ? CNT_MAX : r_edge_cnt + CW'(w_edge);
    assign w_accept = w_term & ~r_first;
    assign w_absent = (w_result < MIN_E);
    assign w_m_x    = {1'b0, w_result};
    assign w_ref_x  = {1'b0, r_ref};
    assign w_diff   = (w_m_x >= w_ref_x) ? (w_m_x - w_ref_x) : (w_ref_x - w_m_x);
    assign w_in_tol = (w_diff <= TOL_X);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_gate       <= '0;
            r_edge_cnt   <= '0;
            r_first      <= 1'b1;
            r_ref        <= '0;
            r_match_cnt  <= '0;
            r_meas_count <= '0;
            r_meas_valid <= 1'b0;
            r_changed    <= 1'b0;
            r_absent     <= 1'b0;
        end else begin
            r_s1 <= clk_tgl_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_term) begin
                r_gate     <= '0;
                r_edge_cnt <= '0;
                r_first    <= 1'b0;
            end else begin
                r_gate <= r_gate + GW'(1);
                if (w_edge && (r_edge_cnt != CNT_MAX))
                    r_edge_cnt <= r_edge_cnt + CW'(1);
            end
            r_meas_valid <= w_accept;
            if (w_accept) begin
                r_meas_count <= w_result;
                r_absent     <= w_absent;
            end
            r_ref       <= w_ref_nxt;
            r_match_cnt <= w_mc_nxt;
            r_changed   <= w_changed_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ACQUIRE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ref_nxt     = r_ref;
        w_mc_nxt      = r_match_cnt;
        w_changed_nxt = 1'b0;
        if (w_accept) begin
            case (r_state)
                ACQUIRE: begin
                    if (w_absent) begin
                        w_ref_nxt = w_result;
                        w_mc_nxt  = '0;
                    end else if (w_in_tol && (r_match_cnt != '0)) begin
                        w_mc_nxt = r_match_cnt + MW'(1);
                        if (w_mc_nxt == MC_DONE)
                            w_state_nxt = STABLE;
                    end else begin
                        w_ref_nxt = w_result;
                        w_mc_nxt  = MW'(1);
                    end
                end
                STABLE: begin
                    // Reference is frozen while settled; slow drift is not tracked.
                    if (w_absent || !w_in_tol) begin
                        w_state_nxt   = ACQUIRE;
                        w_changed_nxt = 1'b1;
                        w_ref_nxt     = w_result;
                        w_mc_nxt      = w_absent ? '0 : MW'(1);
                    end
                end
                default: w_state_nxt = ACQUIRE;
            endcase
        end
    end

    assign meas_count  = r_meas_count;
    assign meas_valid  = r_meas_valid;
    assign clk_stable  = (r_state == STABLE);
    assign clk_changed = r_changed;
    assign clk_absent  = r_absent;

endmodule

// File: tb/tb_vidc_clk_meter.sv
// Directed bench for vidc_clk_meter: per-window vector table plus hand-written
// reset and saturation sequences.
module tb_vidc_clk_meter;

    localparam int G  = 1000;
    localparam int NV = 20;

    typedef struct {
        int period;
        bit alt;
        int lo;
        int hi;
        bit stable;
        bit changed;
        bit absent;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tgl = 1'b0;
    logic        tgl8 = 1'b0;
    logic [15:0] meas_count;
    logic        meas_valid, clk_stable, clk_changed, clk_absent;
    logic [7:0]  meas_count8;
    logic        meas_valid8, clk_stable8, clk_changed8, clk_absent8;

    int nvec, nmis, n_chg, n_both, n_stray, n8, cyc;
    int period, gcnt;
    bit alt, ph;
    vec_t vecs[NV];

    vidc_clk_meter #(.GATE_CYCLES(G), .CW(16), .TOL(4), .STABLE_N(3), .MIN_EDGES(16)) dut (
        .clk(clk), .reset_n(reset_n), .clk_tgl_in(tgl),
        .meas_count(meas_count), .meas_valid(meas_valid), .clk_stable(clk_stable),
        .clk_changed(clk_changed), .clk_absent(clk_absent)
    );

    vidc_clk_meter #(.GATE_CYCLES(G), .CW(8), .TOL(4), .STABLE_N(3), .MIN_EDGES(16)) dut8 (
        .clk(clk), .reset_n(reset_n), .clk_tgl_in(tgl8),
        .meas_count(meas_count8), .meas_valid(meas_valid8), .clk_stable(clk_stable8),
        .clk_changed(clk_changed8), .clk_absent(clk_absent8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        nvec++;
        if (act < lo || act > hi) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2*G + 50; k++) begin
            @(negedge clk);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nmis++;
            $display("FAIL meas_valid_timeout: got no pulse expected one within %0d cycles", 2*G + 50);
        end
    endtask

    // Pixel-toggle stand-in: period 0 holds the level, alt swaps 38/42 intervals.
    initial begin
        gcnt = 0;
        ph   = 1'b0;
        forever begin
            @(negedge clk);
            tgl8 = ~tgl8;
            if (period != 0) begin
                int len;
                len = alt ? (ph ? 42 : 38) : period;
                if (gcnt >= len - 1) begin
                    tgl  = ~tgl;
                    gcnt = 0;
                    ph   = ~ph;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (clk_changed) n_chg++;
            if (clk_changed && clk_stable) n_both++;
            if (clk_changed && !meas_valid) n_stray++;
            if (meas_valid8) begin
                n8++;
                chk("sat_count8", meas_count8, 255);
                chk("sat_absent8", clk_absent8, 0);
            end
        end
    end

    initial begin
        bit ok;
        nvec = 0; nmis = 0; n_chg = 0; n_both = 0; n_stray = 0; n8 = 0;
        // period alt lo  hi  stable changed absent
        vecs[0]  = '{40, 0, 25, 25, 0, 0, 0};
        vecs[1]  = '{40, 0, 25, 25, 0, 0, 0};
        vecs[2]  = '{40, 0, 25, 25, 1, 0, 0};
        vecs[3]  = '{40, 0, 25, 25, 1, 0, 0};
        vecs[4]  = '{20, 0, 47, 52, 0, 1, 0};
        vecs[5]  = '{20, 0, 50, 50, 0, 0, 0};
        vecs[6]  = '{20, 0, 50, 50, 1, 0, 0};
        vecs[7]  = '{40, 1, 23, 27, 0, 1, 0};
        vecs[8]  = '{40, 1, 24, 26, 0, 0, 0};
        vecs[9]  = '{40, 1, 24, 26, 1, 0, 0};
        vecs[10] = '{40, 1, 24, 26, 1, 0, 0};
        vecs[11] = '{40, 1, 24, 26, 1, 0, 0};
        vecs[12] = '{40, 1, 24, 26, 1, 0, 0};
        vecs[13] = '{0,  0, 0,  2,  0, 1, 1};
        vecs[14] = '{0,  0, 0,  0,  0, 0, 1};
        vecs[15] = '{0,  0, 0,  0,  0, 0, 1};
        vecs[16] = '{40, 0, 24, 26, 0, 0, 0};
        vecs[17] = '{40, 0, 25, 25, 0, 0, 0};
        vecs[18] = '{40, 0, 25, 25, 1, 0, 0};
        vecs[19] = '{40, 0, 25, 25, 1, 0, 0};

        period  = vecs[0].period;
        alt     = vecs[0].alt;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_meas_count", meas_count, 0);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_clk_stable", clk_stable, 0);
        chk("rst_clk_changed", clk_changed, 0);
        chk("rst_clk_absent", clk_absent, 0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            wait_valid(ok);
            if (i == 0) chk("first_valid_cycle", cyc, 2*G);
            chk_rng($sformatf("v%0d_count", i), meas_count, vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_stable", i), clk_stable, vecs[i].stable);
            chk($sformatf("v%0d_changed", i), clk_changed, vecs[i].changed);
            chk($sformatf("v%0d_absent", i), clk_absent, vecs[i].absent);
            if (i + 1 < NV) begin
                period = vecs[i+1].period;
                alt    = vecs[i+1].alt;
            end
        end

        // One-cycle reset in the middle of a window while settled.
        repeat (500) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrst_meas_count", meas_count, 0);
        chk("midrst_meas_valid", meas_valid, 0);
        chk("midrst_clk_stable", clk_stable, 0);
        chk("midrst_clk_changed", clk_changed, 0);
        chk("midrst_clk_absent", clk_absent, 0);
        for (int j = 0; j < 3; j++) begin
            wait_valid(ok);
            if (j == 0) chk("midrst_first_valid_cycle", cyc, 2*G);
            chk($sformatf("reacq%0d_count", j), meas_count, 25);
            chk($sformatf("reacq%0d_stable", j), clk_stable, (j == 2) ? 1 : 0);
            chk($sformatf("reacq%0d_changed", j), clk_changed, 0);
        end

        @(negedge clk);
        chk("changed_pulse_cycles", n_chg, 3);
        chk("stable_and_changed_together", n_both, 0);
        chk("changed_without_valid", n_stray, 0);
        chk("sat_windows_seen", (n8 > 0) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
